// File: rtl/store_commit_queue.sv
// Store commit queue: speculative stores wait for commit, committed stores drain
// in order to the dcache store port; a page-offset alias check covers every occupied slot.
module store_commit_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PLEN  = 56,
   parameter int unsigned XLEN  = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_valid_i,
   output logic                       push_ready_o,
   input  logic [PLEN-1:0]            push_addr_i,
   input  logic [XLEN-1:0]            push_data_i,
   input  logic [XLEN/8-1:0]          push_be_i,
   input  logic                       commit_i,
   input  logic                       flush_i,
   output logic                       req_o,
   output logic [PLEN-1:0]            req_addr_o,
   output logic [XLEN-1:0]            req_data_o,
   output logic [XLEN/8-1:0]          req_be_o,
   input  logic                       gnt_i,
   input  logic [11:0]                page_offset_i,
   output logic                       page_offset_match_o,
   output logic                       empty_o,
   output logic                       committed_empty_o,
   output logic [$clog2(DEPTH):0]     n_com_o,
   output logic [$clog2(DEPTH):0]     n_spec_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [PLEN-1:0]   addr_q [DEPTH];
   logic [XLEN-1:0]   data_q [DEPTH];
   logic [XLEN/8-1:0] be_q   [DEPTH];

   logic [AW-1:0] rd_ptr, cm_ptr, wr_ptr;
   logic [CW-1:0] n_com, n_spec, n_total;
   logic          do_push, do_commit, do_pop;

   // Handshakes: a push transfers when push_valid_i & push_ready_o on a rising edge
   // (and no flush); a pop transfers when req_o & gnt_i. req_o and its payload hold
   // steady until granted. Readiness looks only at current occupancy.
   assign n_total      = n_com + n_spec;
   assign push_ready_o = (n_total < CW'(DEPTH));
   assign do_push      = push_valid_i & push_ready_o & ~flush_i;
   assign do_commit    = commit_i & (n_spec != '0);
   assign do_pop       = req_o & gnt_i;

   assign req_o             = (n_com != '0);
   assign req_addr_o        = addr_q[rd_ptr];
   assign req_data_o        = data_q[rd_ptr];
   assign req_be_o          = be_q[rd_ptr];
   assign empty_o           = (n_total == '0);
   assign committed_empty_o = (n_com == '0);
   assign n_com_o           = n_com;
   assign n_spec_o          = n_spec;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         cm_ptr <= '0;
         wr_ptr <= '0;
         n_com  <= '0;
         n_spec <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(do_pop);
         cm_ptr <= cm_ptr + AW'(do_commit);
         n_com  <= n_com + CW'(do_commit) - CW'(do_pop);
         // Flush lands after any same-cycle commit, so wr snaps to the advanced cm.
         if (flush_i) begin
            wr_ptr <= cm_ptr + AW'(do_commit);
            n_spec <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            n_spec <= n_spec + CW'(do_push) - CW'(do_commit);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         addr_q[wr_ptr] <= push_addr_i;
         data_q[wr_ptr] <= push_data_i;
         be_q[wr_ptr]   <= push_be_i;
      end
   end

   always_comb begin
      page_offset_match_o = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < n_total) &&
             (addr_q[rd_ptr + AW'(i)][11:3] == page_offset_i[11:3]))
            page_offset_match_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed bench for store_commit_queue: hand-computed expectations per scenario,
// plus an in-order scoreboard for the continuous stream.
module tb_store_commit_queue;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned PLEN  = 56;
   localparam int unsigned XLEN  = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              push_valid = 1'b0;
   logic              push_ready;
   logic [PLEN-1:0]   push_addr = '0;
   logic [XLEN-1:0]   push_data = '0;
   logic [XLEN/8-1:0] push_be = '0;
   logic              commit = 1'b0;
   logic              flush = 1'b0;
   logic              req;
   logic [PLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_data;
   logic [XLEN/8-1:0] req_be;
   logic              gnt = 1'b0;
   logic [11:0]       page_offset = '0;
   logic              match;
   logic              empty;
   logic              committed_empty;
   logic [3:0]        n_com;
   logic [3:0]        n_spec;

   int n_checks = 0;
   int n_pass   = 0;
   logic [XLEN-1:0] exp_q[$];

   store_commit_queue #(.DEPTH(DEPTH), .PLEN(PLEN), .XLEN(XLEN)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .push_valid_i(push_valid), .push_ready_o(push_ready),
      .push_addr_i(push_addr), .push_data_i(push_data), .push_be_i(push_be),
      .commit_i(commit), .flush_i(flush),
      .req_o(req), .req_addr_o(req_addr), .req_data_o(req_data), .req_be_o(req_be),
      .gnt_i(gnt), .page_offset_i(page_offset), .page_offset_match_o(match),
      .empty_o(empty), .committed_empty_o(committed_empty),
      .n_com_o(n_com), .n_spec_o(n_spec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                           input logic [XLEN/8-1:0] b);
      push_valid = 1'b1;
      push_addr  = a;
      push_data  = d;
      push_be    = b;
      step();
      push_valid = 1'b0;
   endtask

   initial begin
      int sent;
      int got;

      // reset state
      #2;
      check("rst_req", req, 0);
      check("rst_ready", push_ready, 1);
      check("rst_empty", empty, 1);
      check("rst_cempty", committed_empty, 1);
      check("rst_match", match, 0);
      check("rst_ncom", n_com, 0);
      check("rst_nspec", n_spec, 0);
      step();
      rst_n = 1'b1;
      step();

      // single store: push, commit next cycle, grant held high
      gnt = 1'b1;
      push_one(56'h8000_0010, 64'hAA, 8'hFF);
      commit = 1'b1;
      check("t1_no_req_before_commit", req, 0);
      step();
      commit = 1'b0;
      check("t1_req", req, 1);
      check("t1_addr", req_addr, 64'h8000_0010);
      check("t1_data", req_data, 64'hAA);
      check("t1_be", req_be, 64'hFF);
      step();
      check("t1_req_gone", req, 0);
      check("t1_empty", empty, 1);

      // fill with speculative stores, overflow push, then flush
      for (int i = 0; i < 8; i++) begin
         check("t2_ready_fill", push_ready, 1);
         push_one(56'h8000_1000 + 56'(8 * i), 64'h20 + 64'(i), 8'hFF);
      end
      check("t2_ready_full", push_ready, 0);
      check("t2_nspec_full", n_spec, 8);
      push_one(56'h8000_2000, 64'hEE, 8'hFF);
      check("t2_nspec_after_9th", n_spec, 8);
      check("t2_no_req", req, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t2_empty_after_flush", empty, 1);
      check("t2_ready_after_flush", push_ready, 1);

      // 3 pushes, 2 commits, then commit+flush together with a dropped push
      gnt = 1'b0;
      for (int i = 0; i < 3; i++) push_one(56'h8000_3000 + 56'(8 * i), 64'h31 + 64'(i), 8'h0F);
      commit = 1'b1;
      step();
      step();
      flush      = 1'b1;
      push_valid = 1'b1;
      push_data  = 64'h99;
      step();
      commit     = 1'b0;
      flush      = 1'b0;
      push_valid = 1'b0;
      check("t3_ncom", n_com, 3);
      check("t3_nspec", n_spec, 0);
      gnt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("t3_drain_req", req, 1);
         check("t3_drain_data", req_data, 64'h31 + 64'(i));
         step();
      end
      check("t3_req_done", req, 0);
      check("t3_empty", empty, 1);

      // grant withheld for 5 cycles
      gnt = 1'b0;
      push_one(56'h8000_2040, 64'h44, 8'h0F);
      commit = 1'b1;
      step();
      commit = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_req", req, 1);
         check("t4_hold_addr", req_addr, 64'h8000_2040);
         check("t4_hold_data", req_data, 64'h44);
         step();
      end
      gnt = 1'b1;
      check("t4_req_at_gnt", req, 1);
      step();
      check("t4_popped", req, 0);
      check("t4_cempty", committed_empty, 1);

      // page offset alias check
      gnt = 1'b0;
      push_one(56'h8000_1238, 64'h55, 8'hFF);
      page_offset = 12'h23C;
      #1;
      check("t5_match_hit", match, 1);
      page_offset = 12'h240;
      #1;
      check("t5_match_miss", match, 0);
      commit = 1'b1;
      step();
      commit = 1'b0;
      gnt = 1'b1;
      step();
      page_offset = 12'h23C;
      #1;
      check("t5_match_after_drain", match, 0);
      check("t5_empty", empty, 1);

      // continuous push/commit/pop across 20 stores
      sent = 0;
      got  = 0;
      gnt  = 1'b1;
      commit = 1'b1;
      for (int cyc = 0; cyc < 80 && !(sent == 20 && exp_q.size() == 0); cyc++) begin
         push_valid = (sent < 20);
         push_addr  = 56'h8000_4000 + 56'(8 * sent);
         push_data  = 64'h100 + 64'(sent);
         #1;
         if (req) begin
            if (exp_q.size() > 0) check("t6_drain_data", req_data, exp_q.pop_front());
            else check("t6_extra_req", req, 0);
            got++;
         end
         if (push_valid && push_ready) begin
            exp_q.push_back(push_data);
            sent++;
         end
         check("t6_occupancy", 64'(n_com + n_spec <= 4'(DEPTH)), 1);
         step();
      end
      push_valid = 1'b0;
      commit     = 1'b0;
      check("t6_sent", sent, 20);
      check("t6_received", got, 20);
      check("t6_empty", empty, 1);

      // reset in the middle of a drain
      gnt = 1'b0;
      commit = 1'b1;
      for (int i = 0; i < 3; i++) push_one(56'h8000_5000 + 56'(8 * i), 64'h60 + 64'(i), 8'hFF);
      step();
      commit = 1'b0;
      check("t7_ncom_before_rst", n_com, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("t7_req_in_rst", req, 0);
      check("t7_empty_in_rst", empty, 1);
      check("t7_ready_in_rst", push_ready, 1);
      gnt = 1'b1;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t7_no_req_after_rst", req, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
